mem_traffic_gen: RTL and testbench
==================================

# mem_traffic_gen

Parametrised CPU stand-in for the Harvard memory bus. It drives instruction fetches and data reads/writes over configurable wrapping address windows, and honours the `cpu_enable` stall. It counts completed beats, folds fetched instructions into a checksum, and stops after a programmable number of beats. It replaces the hand-written fixed-pattern stub in memory-subsystem benches, and is synthesisable so the same pattern runs on FPGA.

## Interface
- `INSTR_BASE`, 32'h0000_0004, first instruction address; wrap target.
- `INSTR_LIMIT`, 32'h0000_002C, last instruction address before wrap.
- `DATA_BASE`, 32'hFFFF_0004, first data address; wrap target.
- `DATA_LIMIT`, 32'hFFFF_001C, last data address before wrap.
- `STRIDE`, 4, address increment in bytes.
- `MAX_BEATS`, 100, completed beats before DONE; 1..65535.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_enable`  in  1  beat-complete qualifier; 0 = stall.
- `start`  in  1  begin run; sampled only in IDLE.
- `mode`  in  2  0 READ, 1 ALT_RW, 2 WRITE, 3 = treated as READ; sampled with `start`.
- `instr_readdata`  in  32  instruction bus return data.
- `data_readdata`  in  32  data bus return data.
- `instr_address`  out  32  current fetch address.
- `data_address`  out  32  current data address.
- `data_writedata`  out  32  write data.
- `data_read`  out  1  data read strobe.
- `data_write`  out  1  data write strobe.
- `active`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `beat_count`  out  16  completed beats.
- `register_v0`  out  32  running checksum.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `instr_address`=INSTR_BASE, `data_address`=DATA_BASE, `data_writedata`=0, strobes 0, `active`=0, `done`=0, `beat_count`=0, `register_v0`=0.
- IDLE→RUN on `start`=1. The mode latches on the same edge. The first beat's strobes are registered and valid the next cycle.
- In RUN, one beat is presented at a time. A beat completes on a rising edge with `cpu_enable`=1. With `cpu_enable`=0 every output holds.
- On beat completion:
  - `beat_count`+1.
  - `register_v0` ^= `instr_readdata`.
  - `instr_address` advances.
  - Data-side update follows the mode rules below.
- Address advance: if address == LIMIT, next = BASE; else next = address + STRIDE. Arithmetic is 32-bit modulo.
- READ mode:
  - Every beat has `data_read`=1 and `data_write`=0.
  - `data_address` advances every beat.
- ALT_RW mode:
  - Beats alternate read, write, read, and so on, starting with read.
  - A read beat captures `data_readdata` into `data_writedata`.
  - The following write beat writes it to the same `data_address`.
  - `data_address` advances only after a write beat.
- WRITE mode:
  - Every beat has `data_write`=1.
  - `data_writedata` = `data_address` of that beat.
  - `data_address` advances every beat.
- `data_read` and `data_write` are never both 1.
- RUN→DONE on completion of beat `MAX_BEATS`. DONE drives strobes 0, `active`=0 and `done`=1, and holds addresses, count and checksum. DONE exits only by reset.
- `start` in RUN or DONE is ignored. `mode` changes mid-run are ignored.
- `reset` in any state returns to IDLE with reset values on the next edge. This overrides a simultaneous beat completion.

## Timing
- Strobe and address latency: 1 cycle from the `start` edge.
- Beat completion is the same edge as `cpu_enable`=1. The next beat's outputs are valid in the following cycle.
- Read data is sampled on the completing edge: `data_readdata` for the ALT_RW capture, `instr_readdata` for the checksum.
- Unstalled throughput: 1 beat/cycle.
- DONE asserts the cycle after the final completing edge.

## Test plan
- Reset then `start`, mode 0, `cpu_enable`=1 constantly, MAX_BEATS=12 → instruction addresses 4,8,…,2C,4. Data addresses FFFF0004…FFFF001C, then wrap to FFFF0004 on beat 8. `done`=1 after beat 12, `beat_count`=12.
- Mode 1, `data_readdata`=A5A5_0001 on beat 1 → beat 2 has `data_write`=1 at FFFF0004 with `data_writedata`=A5A5_0001. Beat 3 reads FFFF0008.
- Mode 2 → beats write FFFF0004, FFFF0008… with `data_writedata` equal to the address. `data_read`=0 throughout.
- Stall: `cpu_enable`=0 for 5 cycles mid-run → all outputs frozen and `beat_count` unchanged. Resumes on the next enabled edge.
- Checksum: `instr_readdata`=0000_00FF then 0000_0F0F over 2 beats → `register_v0`=0000_0FF0.
- `reset` asserted in RUN at beat 3 while `cpu_enable`=1 → IDLE with all reset values next cycle. `start` while in DONE → no effect.

Source files
------------

// File: rtl/mem_traffic_gen.sv
// CPU stand-in for the Harvard memory bus: wrapping fetch/data address
// windows, read/alt/write data patterns, beat counter and fetch checksum.
module mem_traffic_gen #(
    parameter logic [31:0] INSTR_BASE  = 32'h0000_0004,
    parameter logic [31:0] INSTR_LIMIT = 32'h0000_002C,
    parameter logic [31:0] DATA_BASE   = 32'hFFFF_0004,
    parameter logic [31:0] DATA_LIMIT  = 32'hFFFF_001C,
    parameter int          STRIDE      = 4,
    parameter int          MAX_BEATS   = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_enable,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [31:0] instr_readdata,
    input  logic [31:0] data_readdata,
    output logic [31:0] instr_address,
    output logic [31:0] data_address,
    output logic [31:0] data_writedata,
    output logic        data_read,
    output logic        data_write,
    output logic        active,
    output logic        done,
    output logic [15:0] beat_count,
    output logic [31:0] register_v0
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_READ  = 2'd0;
    localparam logic [1:0] M_ALT   = 2'd1;
    localparam logic [1:0] M_WRITE = 2'd2;

    state_t      state, state_nx;
    logic [1:0]  mode_q;
    logic        wr_phase;
    logic        beat;
    logic        last;
    logic [31:0] instr_nx;
    logic [31:0] data_nx;

    function automatic logic [31:0] adv(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input logic [31:0] lim);
        return (a == lim) ? base : a + 32'(STRIDE);
    endfunction

    assign beat     = (state == S_RUN) && cpu_enable;
    assign last     = (beat_count == 16'(MAX_BEATS - 1));
    assign instr_nx = adv(instr_address, INSTR_BASE, INSTR_LIMIT);
    assign data_nx  = adv(data_address, DATA_BASE, DATA_LIMIT);
    assign active   = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (beat && last) state_nx = S_DONE;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_address  <= INSTR_BASE;
            data_address   <= DATA_BASE;
            data_writedata <= '0;
            data_read      <= 1'b0;
            data_write     <= 1'b0;
            beat_count     <= '0;
            register_v0    <= '0;
            mode_q         <= M_READ;
            wr_phase       <= 1'b0;
        end else if (state == S_IDLE && start) begin
            // mode 3 collapses to READ at latch time
            mode_q     <= (mode == 2'd3) ? M_READ : mode;
            wr_phase   <= 1'b0;
            data_read  <= (mode != M_WRITE);
            data_write <= (mode == M_WRITE);
            if (mode == M_WRITE) data_writedata <= data_address;
        end else if (beat) begin
            beat_count    <= beat_count + 16'd1;
            register_v0   <= register_v0 ^ instr_readdata;
            instr_address <= instr_nx;
            case (mode_q)
                M_ALT: begin
                    if (wr_phase) data_address   <= data_nx;
                    else          data_writedata <= data_readdata;
                    wr_phase <= ~wr_phase;
                end
                M_WRITE: begin
                    data_address   <= data_nx;
                    data_writedata <= data_nx;
                end
                default: data_address <= data_nx;
            endcase
            // strobes describe the beat presented next cycle
            data_read  <= !last && ((mode_q == M_ALT) ? wr_phase
                                                      : (mode_q != M_WRITE));
            data_write <= !last && ((mode_q == M_ALT) ? !wr_phase
                                                      : (mode_q == M_WRITE));
        end
    end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: directed table, stall/reset sequence and
// randomized runs against a per-beat arithmetic reference model.
module tb_mem_traffic_gen;

    localparam int MAXB = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_enable = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] instr_readdata = '0;
    logic [31:0] data_readdata = '0;
    logic [31:0] instr_address, data_address, data_writedata;
    logic        data_read, data_write, active, done;
    logic [15:0] beat_count;
    logic [31:0] register_v0;

    int vectors = 0;
    int miscompares = 0;

    mem_traffic_gen #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset), .cpu_enable(cpu_enable),
        .start(start), .mode(mode),
        .instr_readdata(instr_readdata), .data_readdata(data_readdata),
        .instr_address(instr_address), .data_address(data_address),
        .data_writedata(data_writedata), .data_read(data_read),
        .data_write(data_write), .active(active), .done(done),
        .beat_count(beat_count), .register_v0(register_v0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] ird0, ird1, drd0;
        logic        rd1, wr1;
        logic [31:0] da1, wd1, da2, v0;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_enable = 1'b0;
        start = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic begin_run(input logic [1:0] m);
        mode = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " ia"}, instr_address, 32'h0000_0004);
        chk({tag, " da"}, data_address, 32'hFFFF_0004);
        chk({tag, " wd"}, data_writedata, 32'h0);
        chk({tag, " rd"}, 32'(data_read), 32'h0);
        chk({tag, " wr"}, 32'(data_write), 32'h0);
        chk({tag, " active"}, 32'(active), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " bc"}, 32'(beat_count), 32'h0);
        chk({tag, " v0"}, register_v0, 32'h0);
    endtask

    task automatic rand_run(input logic [1:0] m);
        int k = 0;
        int cyc = 0;
        logic [1:0]  em;
        logic [31:0] v0 = '0;
        logic [31:0] cap = '0;
        logic [31:0] eia, eda, ewd;
        logic        erd, ewr;
        do_reset();
        begin_run(m);
        em = (m == 2'd3) ? 2'd0 : m;
        while (k < MAXB && cyc < 400) begin
            eia = 32'h4 + 32'((k % 11) * 4);
            if (em == 2'd1) begin
                eda = 32'hFFFF_0004 + 32'(((k / 2) % 7) * 4);
                erd = (k % 2 == 0);
                ewr = (k % 2 == 1);
                ewd = cap;
            end else begin
                eda = 32'hFFFF_0004 + 32'((k % 7) * 4);
                erd = (em == 2'd0);
                ewr = (em == 2'd2);
                ewd = (em == 2'd2) ? eda : 32'h0;
            end
            chk("run ia", instr_address, eia);
            chk("run da", data_address, eda);
            chk("run wd", data_writedata, ewd);
            chk("run rd", 32'(data_read), 32'(erd));
            chk("run wr", 32'(data_write), 32'(ewr));
            chk("run bc", 32'(beat_count), 32'(k));
            chk("run v0", register_v0, v0);
            chk("run active", 32'(active), 32'h1);
            cpu_enable = ($urandom_range(0, 3) != 0);
            instr_readdata = $urandom;
            data_readdata = $urandom;
            start = 1'($urandom);
            mode = 2'($urandom);
            if (cpu_enable) begin
                v0 ^= instr_readdata;
                if (em == 2'd1 && k % 2 == 0) cap = data_readdata;
                k++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        cpu_enable = 1'b0;
        if (k < MAXB) chk("run timeout", 32'(k), 32'(MAXB));
        for (int i = 0; i < 3; i++) begin
            chk("done flag", 32'(done), 32'h1);
            chk("done active", 32'(active), 32'h0);
            chk("done rd", 32'(data_read), 32'h0);
            chk("done wr", 32'(data_write), 32'h0);
            chk("done bc", 32'(beat_count), 32'(MAXB));
            chk("done v0", register_v0, v0);
            start = 1'b1;
            cpu_enable = 1'b1;
            step();
        end
        start = 1'b0;
        cpu_enable = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'd0, 32'hFF, 32'hF0F, 32'h1234, 1'b1, 1'b0,
                   32'hFFFF_0008, 32'h0, 32'hFFFF_000C, 32'hFF0};
        tbl[1] = '{2'd1, 32'h1, 32'h2, 32'hA5A5_0001, 1'b0, 1'b1,
                   32'hFFFF_0004, 32'hA5A5_0001, 32'hFFFF_0008, 32'h3};
        tbl[2] = '{2'd2, 32'hF0, 32'hF0, 32'h5555, 1'b0, 1'b1,
                   32'hFFFF_0008, 32'hFFFF_0008, 32'hFFFF_000C, 32'h0};
        tbl[3] = '{2'd3, 32'hAA, 32'h55, 32'h9999, 1'b1, 1'b0,
                   32'hFFFF_0008, 32'h0, 32'hFFFF_000C, 32'hFF};

        do_reset();
        check_reset("reset");

        foreach (tbl[i]) begin
            do_reset();
            begin_run(tbl[i].m);
            cpu_enable = 1'b1;
            instr_readdata = tbl[i].ird0;
            data_readdata = tbl[i].drd0;
            step();
            chk("tbl rd1", 32'(data_read), 32'(tbl[i].rd1));
            chk("tbl wr1", 32'(data_write), 32'(tbl[i].wr1));
            chk("tbl da1", data_address, tbl[i].da1);
            chk("tbl wd1", data_writedata, tbl[i].wd1);
            instr_readdata = tbl[i].ird1;
            step();
            cpu_enable = 1'b0;
            chk("tbl da2", data_address, tbl[i].da2);
            chk("tbl v0", register_v0, tbl[i].v0);
            chk("tbl bc", 32'(beat_count), 32'h2);
        end

        do_reset();
        begin_run(2'd0);
        cpu_enable = 1'b1;
        step();
        step();
        cpu_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall bc", 32'(beat_count), 32'h2);
            chk("stall ia", instr_address, 32'h0000_000C);
            chk("stall da", data_address, 32'hFFFF_000C);
            chk("stall rd", 32'(data_read), 32'h1);
        end
        cpu_enable = 1'b1;
        step();
        chk("resume bc", 32'(beat_count), 32'h3);
        chk("resume ia", instr_address, 32'h0000_0010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cpu_enable = 1'b0;
        check_reset("mid reset");

        for (int r = 0; r < 3; r++)
            for (int m = 0; m < 4; m++) rand_run(2'(m));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
